// File: rtl/pad_responder.sv
// ============================================================================
// Module   : pad_responder
// Purpose  : Device-side model of the guitar controller serial link. Answers
//            the host poll (BCclk/BCcommand/BCattention) by shifting response
//            bytes out on BCdata and strobing BCack after each byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pad_responder #(
    parameter logic [7:0] ID_BYTE   = 8'h41,
    parameter int         ACK_DELAY = 100,
    parameter int         ACK_WIDTH = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BCclk,
    input  logic        BCcommand,
    input  logic        BCattention,
    input  logic [15:0] buttons,
    output logic        BCdata,
    output logic        BCack,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] poll_count
);

    localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT     = 3'd1;
    localparam logic [2:0] S_ACK_WAIT  = 3'd2;
    localparam logic [2:0] S_ACK_PULSE = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_IGNORE    = 3'd5;

    // Bit order in sync vectors: [2]=BCclk, [1]=BCcommand, [0]=BCattention
    logic [2:0]    meta_q, sync_q;
    logic          clk_prev_q;
    logic          w_rise, w_fall, w_cmd, w_att_n;

    logic [2:0]    state_q, state_d;
    logic [2:0]    byte_idx_q, byte_idx_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [15:0]   snap_q, snap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          data_q, data_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   poll_q, poll_d;
    logic [7:0]    w_rx_next;
    logic [7:0]    w_tx_next;
    logic          w_bad;

    // Two-flop synchronizers plus a delayed BCclk copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 3'b111;
            sync_q     <= 3'b111;
            clk_prev_q <= 1'b1;
        end else begin
            meta_q     <= {BCclk, BCcommand, BCattention};
            sync_q     <= meta_q;
            clk_prev_q <= sync_q[2];
        end
    end

    assign w_rise    =  sync_q[2] & ~clk_prev_q;
    assign w_fall    = ~sync_q[2] &  clk_prev_q;
    assign w_cmd     =  sync_q[1];
    assign w_att_n   =  sync_q[0];
    assign w_rx_next = {w_cmd, rx_q[7:1]};
    assign w_bad     = ((byte_idx_q == 3'd0) && (w_rx_next != 8'h01)) ||
                       ((byte_idx_q == 3'd1) && (w_rx_next != 8'h42));

    // Response byte for the byte that follows the one just completed
    always_comb begin
        case (byte_idx_q)
            3'd0:    w_tx_next = ID_BYTE;
            3'd1:    w_tx_next = 8'h5A;
            3'd2:    w_tx_next = ~snap_q[7:0];
            default: w_tx_next = ~snap_q[15:8];
        endcase
    end

    // Frame state machine; attention release overrides any clock edge
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        snap_d     = snap_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        ack_d      = ack_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        poll_d     = poll_q;
        if (w_att_n) begin
            if (state_q != S_IDLE) begin
                state_d    = S_IDLE;
                data_d     = 1'b1;
                ack_d      = 1'b1;
                byte_idx_d = 3'd0;
                bit_cnt_d  = 3'd0;
                cnt_d      = '0;
                err_d      = (state_q == S_SHIFT) || (state_q == S_ACK_WAIT) ||
                             (state_q == S_ACK_PULSE);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_SHIFT;
                    byte_idx_d = 3'd0;
                    bit_cnt_d  = 3'd0;
                    tx_d       = 8'hFF;
                    snap_d     = buttons;
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        data_d = tx_q[bit_cnt_q];
                    end else if (w_rise) begin
                        rx_d      = w_rx_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (w_bad) begin
                                state_d = S_IGNORE;
                                data_d  = 1'b1;
                            end else if (byte_idx_q == 3'd4) begin
                                state_d = S_DONE;
                                data_d  = 1'b1;
                                done_d  = 1'b1;
                                poll_d  = poll_q + 16'd1;
                            end else begin
                                state_d    = S_ACK_WAIT;
                                byte_idx_d = byte_idx_q + 3'd1;
                                tx_d       = w_tx_next;
                                cnt_d      = '0;
                            end
                        end
                    end
                end
                S_ACK_WAIT, S_ACK_PULSE: begin
                    // An early host clock fall cuts the ack short and is bit 0
                    if (w_fall) begin
                        state_d = S_SHIFT;
                        ack_d   = 1'b1;
                        data_d  = tx_q[bit_cnt_q];
                        cnt_d   = '0;
                    end else if (state_q == S_ACK_WAIT) begin
                        if (cnt_q == CW'(ACK_DELAY - 1)) begin
                            state_d = S_ACK_PULSE;
                            ack_d   = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        if (cnt_q == CW'(ACK_WIDTH - 1)) begin
                            state_d = S_SHIFT;
                            ack_d   = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE, S_IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 8'hFF;
            rx_q       <= 8'h00;
            snap_q     <= 16'h0000;
            cnt_q      <= '0;
            data_q     <= 1'b1;
            ack_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            poll_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            poll_q     <= poll_d;
        end
    end

    assign BCdata     = data_q;
    assign BCack      = ack_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign poll_count = poll_q;

endmodule

`default_nettype wire
